// File: rtl/riscv_mc_control_pkg.sv
// riscv_mc_control_pkg: shared codes, state enum and ALU decode helper for the multicycle RV32I controller
package riscv_mc_control_pkg;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_SLL   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_SLT   = 4'd8;
  localparam logic [3:0] ALU_SLTU  = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;
  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_J = 3'd3;
  localparam logic [2:0] IMM_U = 3'd4;
  localparam logic [1:0] A_PC = 2'd0, A_OLDPC = 2'd1, A_RS1 = 2'd2;
  localparam logic [1:0] B_RS2 = 2'd0, B_IMM = 2'd1, B_FOUR = 2'd2;
  localparam logic [1:0] RES_ALUOUT = 2'd0, RES_DATA = 2'd1, RES_ALU = 2'd2;
  localparam logic [1:0] FLT_ILLEGAL = 2'b01, FLT_TIMEOUT = 2'b10;
  typedef enum logic [4:0] {
    S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXEC_R, S_EXEC_I, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_JALR2,
    S_LUI, S_AUIPC, S_HALT
  } state_t;
  // funct7[5] selects SUB only for register ops; immediate ADDI never subtracts
  function automatic logic [3:0] alu_dec(input logic [2:0] f3, input logic f7_5, input logic is_r);
    case (f3)
      3'b000:  return (is_r && f7_5) ? ALU_SUB : ALU_ADD;
      3'b111:  return ALU_AND;
      3'b110:  return ALU_OR;
      3'b100:  return ALU_XOR;
      3'b001:  return ALU_SLL;
      3'b101:  return f7_5 ? ALU_SRA : ALU_SRL;
      3'b010:  return ALU_SLT;
      default: return ALU_SLTU;
    endcase
  endfunction
endpackage

// File: rtl/riscv_mc_control_if.sv
// riscv_mc_control_if: controller <-> datapath/memory bundle
//  master: controller (takes IR fields, ALU flags, mem_ready; drives enables, selects, alu_ctrl, retire, fault)
//  slave : datapath/memory side
interface riscv_mc_control_if #(parameter int ALU_CTRL_W = 4);
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic zero, lt, ltu, mem_ready;
  logic mem_req, mem_write, adr_src, pc_write, ir_write, reg_write, retire;
  logic [2:0] imm_src;
  logic [1:0] alu_src_a, alu_src_b, result_src, fault;
  logic [ALU_CTRL_W-1:0] alu_ctrl;
  modport master (
    input  opcode, funct3, funct7, zero, lt, ltu, mem_ready,
    output mem_req, mem_write, adr_src, pc_write, ir_write, reg_write, retire,
           imm_src, alu_src_a, alu_src_b, result_src, fault, alu_ctrl
  );
  modport slave (
    output opcode, funct3, funct7, zero, lt, ltu, mem_ready,
    input  mem_req, mem_write, adr_src, pc_write, ir_write, reg_write, retire,
           imm_src, alu_src_a, alu_src_b, result_src, fault, alu_ctrl
  );
endinterface

// File: rtl/riscv_mc_control.sv
// riscv_mc_control: multicycle RV32I control FSM with memory handshake, timeout and sticky faults
//  clk, rst_n (async active-low); bus: riscv_mc_control_if.master
//  MEM_TIMEOUT = max wait cycles per memory access (0 disables the timeout)
module riscv_mc_control
  import riscv_mc_control_pkg::*;
#(
  parameter int ALU_CTRL_W  = 4,
  parameter int MEM_TIMEOUT = 0
) (
  input  logic clk,
  input  logic rst_n,
  riscv_mc_control_if.master bus
);
  localparam int CW = MEM_TIMEOUT > 0 ? $clog2(MEM_TIMEOUT + 1) : 1;
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [1:0] r_fault, w_flt;
  logic [3:0] w_alu;
  logic w_tmo, w_br_ok, w_taken;
  assign w_tmo = (MEM_TIMEOUT > 0) && (r_cnt == CW'(MEM_TIMEOUT));
  // funct3 010/011 are not branches; bit0 inverts the base condition
  assign w_br_ok = bus.funct3[2:1] != 2'b01;
  assign w_taken = w_br_ok & ((bus.funct3[2] ? (bus.funct3[1] ? bus.ltu : bus.lt) : bus.zero) ^ bus.funct3[0]);
  assign bus.alu_ctrl = ALU_CTRL_W'(w_alu);
  assign bus.fault = r_fault;
  always_comb begin
    w_next = r_state;
    w_flt = 2'b00;
    case (r_state)
      S_IDLE:     w_next = S_FETCH;
      S_FETCH:    w_next = bus.mem_ready ? S_DECODE : (w_tmo ? S_HALT : S_FETCH);
      S_DECODE:
        case (bus.opcode)
          OP_LOAD, OP_STORE: w_next = S_MEMADR;
          OP_R:              w_next = S_EXEC_R;
          OP_I:              w_next = S_EXEC_I;
          OP_BR:             w_next = S_BRANCH;
          OP_JAL:            w_next = S_JAL;
          OP_JALR:           w_next = S_JALR;
          OP_LUI:            w_next = S_LUI;
          OP_AUIPC:          w_next = S_AUIPC;
          default: begin
            w_next = S_HALT;
            w_flt = FLT_ILLEGAL;
          end
        endcase
      S_MEMADR:   w_next = bus.opcode == OP_LOAD ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  w_next = bus.mem_ready ? S_MEMWB : (w_tmo ? S_HALT : S_MEMREAD);
      S_MEMWRITE: w_next = bus.mem_ready ? S_FETCH : (w_tmo ? S_HALT : S_MEMWRITE);
      S_MEMWB, S_ALUWB: w_next = S_FETCH;
      S_EXEC_R, S_EXEC_I, S_JAL, S_JALR2, S_LUI, S_AUIPC: w_next = S_ALUWB;
      S_JALR:     w_next = S_JALR2;
      S_BRANCH: begin
        w_next = w_br_ok ? S_FETCH : S_HALT;
        w_flt = w_br_ok ? 2'b00 : FLT_ILLEGAL;
      end
      default:    w_next = S_HALT;
    endcase
    if (w_next == S_HALT && r_state != S_HALT && w_flt == 2'b00) w_flt = FLT_TIMEOUT;
  end
  always_comb begin
    bus.mem_req = 1'b0;
    bus.mem_write = 1'b0;
    bus.adr_src = 1'b0;
    bus.pc_write = 1'b0;
    bus.ir_write = 1'b0;
    bus.reg_write = 1'b0;
    bus.retire = 1'b0;
    bus.imm_src = IMM_I;
    bus.alu_src_a = A_PC;
    bus.alu_src_b = B_RS2;
    bus.result_src = RES_ALUOUT;
    w_alu = ALU_ADD;
    case (r_state)
      S_FETCH: begin
        bus.mem_req = 1'b1;
        bus.alu_src_b = B_FOUR;
        bus.result_src = RES_ALU;
        bus.pc_write = bus.mem_ready;
        bus.ir_write = bus.mem_ready;
      end
      S_DECODE: begin
        bus.alu_src_a = A_OLDPC;
        bus.alu_src_b = B_IMM;
        bus.imm_src = bus.opcode == OP_JAL ? IMM_J : IMM_B;
      end
      S_MEMADR: begin
        bus.alu_src_a = A_RS1;
        bus.alu_src_b = B_IMM;
        bus.imm_src = bus.opcode == OP_STORE ? IMM_S : IMM_I;
      end
      S_MEMREAD: begin
        bus.mem_req = 1'b1;
        bus.adr_src = 1'b1;
      end
      S_MEMWB: begin
        bus.result_src = RES_DATA;
        bus.reg_write = 1'b1;
        bus.retire = 1'b1;
      end
      S_MEMWRITE: begin
        bus.mem_req = 1'b1;
        bus.mem_write = 1'b1;
        bus.adr_src = 1'b1;
        bus.retire = bus.mem_ready;
      end
      S_EXEC_R: begin
        bus.alu_src_a = A_RS1;
        w_alu = alu_dec(bus.funct3, bus.funct7[5], 1'b1);
      end
      S_EXEC_I: begin
        bus.alu_src_a = A_RS1;
        bus.alu_src_b = B_IMM;
        w_alu = alu_dec(bus.funct3, bus.funct7[5], 1'b0);
      end
      S_ALUWB: begin
        bus.reg_write = 1'b1;
        bus.retire = 1'b1;
      end
      S_BRANCH: begin
        bus.alu_src_a = A_RS1;
        w_alu = ALU_SUB;
        bus.pc_write = w_taken;
        bus.retire = w_br_ok;
      end
      // ALUOut already holds the target; the ALU meanwhile forms the link OldPC+4
      S_JAL, S_JALR2: begin
        bus.pc_write = 1'b1;
        bus.alu_src_a = A_OLDPC;
        bus.alu_src_b = B_FOUR;
      end
      S_JALR: begin
        bus.alu_src_a = A_RS1;
        bus.alu_src_b = B_IMM;
      end
      S_LUI: begin
        bus.alu_src_b = B_IMM;
        bus.imm_src = IMM_U;
        w_alu = ALU_PASSB;
      end
      S_AUIPC: begin
        bus.alu_src_a = A_OLDPC;
        bus.alu_src_b = B_IMM;
        bus.imm_src = IMM_U;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt <= '0;
      r_fault <= 2'b00;
    end else begin
      r_state <= w_next;
      r_cnt <= (w_next != r_state) ? '0 : r_cnt + CW'(bus.mem_req & ~bus.mem_ready);
      r_fault <= r_fault | w_flt;
    end
  end
endmodule

// File: tb/tb_riscv_mc_control.sv
// tb_riscv_mc_control: directed self-checking bench for riscv_mc_control
module tb_riscv_mc_control;
  import riscv_mc_control_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rdy1 = 1'b1;
  int n_vec = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  riscv_mc_control_if #(.ALU_CTRL_W(4)) bus0 ();
  riscv_mc_control_if #(.ALU_CTRL_W(4)) bus1 ();
  assign bus1.opcode = bus0.opcode;
  assign bus1.funct3 = bus0.funct3;
  assign bus1.funct7 = bus0.funct7;
  assign bus1.zero = bus0.zero;
  assign bus1.lt = bus0.lt;
  assign bus1.ltu = bus0.ltu;
  assign bus1.mem_ready = rdy1;
  riscv_mc_control #(.ALU_CTRL_W(4), .MEM_TIMEOUT(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  riscv_mc_control #(.ALU_CTRL_W(4), .MEM_TIMEOUT(2)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    bus0.opcode = op;
    bus0.funct3 = f3;
    bus0.funct7 = f7;
    bus0.mem_ready = 1'b1;
    #1;
  endtask
  // leaves both DUTs in FETCH, 1 ns after the edge
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_fault", bus0.fault, 0);
    chk("rst_mem_req", bus0.mem_req, 0);
    chk("rst_fault1", bus1.fault, 0);
    step();
    rst_n = 1'b1;
    #1;
    chk("idle_mem_req", bus0.mem_req, 0);
    step();
  endtask
  task automatic run_alu(input string tag, input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [3:0] exp_alu);
    drive(op, f3, f7);
    chk({tag, "_fetch_pcw"}, bus0.pc_write, 1);
    step();
    step();
    chk({tag, "_alu"}, bus0.alu_ctrl, exp_alu);
    step();
    chk({tag, "_regw"}, bus0.reg_write, 1);
    chk({tag, "_retire"}, bus0.retire, 1);
    step();
  endtask
  task automatic run_branch(input string tag, input logic [2:0] f3, input logic z, input logic l, input logic lu,
                            input logic exp_taken);
    drive(OP_BR, f3, 7'd0);
    bus0.zero = z;
    bus0.lt = l;
    bus0.ltu = lu;
    step();
    step();
    #1;
    chk({tag, "_pcw"}, bus0.pc_write, exp_taken);
    chk({tag, "_retire"}, bus0.retire, 1);
    chk({tag, "_res"}, bus0.result_src, RES_ALUOUT);
    step();
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [8:0] exp_pcw;
    logic [8:0] exp_rw;
    int n_ret;
    bus0.opcode = 7'd0;
    bus0.funct3 = 3'd0;
    bus0.funct7 = 7'd0;
    bus0.zero = 1'b0;
    bus0.lt = 1'b0;
    bus0.ltu = 1'b0;
    bus0.mem_ready = 1'b0;
    do_reset();
    // R-type SUB with detailed per-cycle view
    drive(OP_R, 3'b000, 7'b0100000);
    chk("r_fetch_req", bus0.mem_req, 1);
    chk("r_fetch_irw", bus0.ir_write, 1);
    chk("r_fetch_srcb", bus0.alu_src_b, B_FOUR);
    chk("r_fetch_res", bus0.result_src, RES_ALU);
    step();
    chk("r_dec_srca", bus0.alu_src_a, A_OLDPC);
    chk("r_dec_imm", bus0.imm_src, IMM_B);
    step();
    chk("r_exec_alu", bus0.alu_ctrl, ALU_SUB);
    chk("r_exec_srcb", bus0.alu_src_b, B_RS2);
    chk("r_exec_regw", bus0.reg_write, 0);
    step();
    chk("r_wb_regw", bus0.reg_write, 1);
    chk("r_wb_retire", bus0.retire, 1);
    step();
    chk("r_next_fetch", bus0.mem_req, 1);
    chk("r_next_retire", bus0.retire, 0);
    run_alu("srai", OP_I, 3'b101, 7'b0100000, ALU_SRA);
    run_alu("addi_f7", OP_I, 3'b000, 7'b0100000, ALU_ADD);
    run_alu("sltu", OP_R, 3'b011, 7'd0, ALU_SLTU);
    run_alu("lui", OP_LUI, 3'b000, 7'd0, ALU_PASSB);
    // load with three wait cycles in MEMREAD
    drive(OP_LOAD, 3'b010, 7'd0);
    step();
    step();
    chk("ld_adr_imm", bus0.imm_src, IMM_I);
    chk("ld_adr_srca", bus0.alu_src_a, A_RS1);
    step();
    for (int i = 0; i < 4; i++) begin
      bus0.mem_ready = (i == 3);
      #1;
      chk("ld_rd_req", bus0.mem_req, 1);
      chk("ld_rd_adr", bus0.adr_src, 1);
      chk("ld_rd_regw", bus0.reg_write, 0);
      step();
    end
    chk("ld_wb_regw", bus0.reg_write, 1);
    chk("ld_wb_res", bus0.result_src, RES_DATA);
    chk("ld_wb_retire", bus0.retire, 1);
    chk("ld_wb_req", bus0.mem_req, 0);
    step();
    // store, ready immediately
    drive(OP_STORE, 3'b010, 7'd0);
    step();
    step();
    chk("st_adr_imm", bus0.imm_src, IMM_S);
    step();
    chk("st_wr", bus0.mem_write, 1);
    chk("st_retire", bus0.retire, 1);
    step();
    run_branch("bne_z1", 3'b001, 1'b1, 1'b0, 1'b0, 1'b0);
    run_branch("bne_z0", 3'b001, 1'b0, 1'b0, 1'b0, 1'b1);
    run_branch("blt", 3'b100, 1'b0, 1'b1, 1'b0, 1'b1);
    run_branch("bgeu", 3'b111, 1'b0, 1'b1, 1'b1, 1'b0);
    // JAL followed by JALR
    exp_pcw = 9'b010010101;
    exp_rw = 9'b100001000;
    n_ret = 0;
    drive(OP_JAL, 3'b000, 7'd0);
    for (int i = 0; i < 9; i++) begin
      if (i == 4) bus0.opcode = OP_JALR;
      #1;
      chk("jj_pcw", bus0.pc_write, exp_pcw[i]);
      chk("jj_regw", bus0.reg_write, exp_rw[i]);
      if (i == 1) chk("jal_dec_imm", bus0.imm_src, IMM_J);
      if (i == 6) chk("jalr_imm", bus0.imm_src, IMM_I);
      n_ret += int'(bus0.retire);
      step();
    end
    chk("jj_retires", n_ret, 2);
    // no timeout when MEM_TIMEOUT = 0
    bus0.mem_ready = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("nto_fault", bus0.fault, 0);
    chk("nto_req", bus0.mem_req, 1);
    // illegal branch funct3
    drive(OP_BR, 3'b010, 7'd0);
    step();
    step();
    chk("ibr_fault_pre", bus0.fault, 0);
    chk("ibr_pcw", bus0.pc_write, 0);
    step();
    chk("ibr_fault", bus0.fault, FLT_ILLEGAL);
    do_reset();
    // illegal opcode, then reset mid-HALT
    drive(7'b1111111, 3'b000, 7'd0);
    step();
    chk("ill_dec_fault", bus0.fault, 0);
    step();
    chk("ill_fault", bus0.fault, FLT_ILLEGAL);
    chk("ill_req", bus0.mem_req, 0);
    step();
    step();
    chk("ill_sticky", bus0.fault, FLT_ILLEGAL);
    do_reset();
    chk("ill_reset_fault", bus0.fault, 0);
    chk("ill_refetch", bus0.mem_req, 1);
    // MEM_TIMEOUT = 2: ready on the third wait cycle still wins
    drive(OP_R, 3'b000, 7'd0);
    rdy1 = 1'b0;
    #1;
    chk("to_bnd_req", bus1.mem_req, 1);
    step();
    step();
    rdy1 = 1'b1;
    #1;
    chk("to_bnd_irw", bus1.ir_write, 1);
    step();
    chk("to_bnd_fault", bus1.fault, 0);
    chk("to_bnd_dec", bus1.mem_req, 0);
    do_reset();
    rdy1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("to_wait_fault", bus1.fault, 0);
      chk("to_wait_req", bus1.mem_req, 1);
      step();
    end
    chk("to_fault", bus1.fault, FLT_TIMEOUT);
    chk("to_halt_req", bus1.mem_req, 0);
    rdy1 = 1'b1;
    step();
    step();
    chk("to_halt_sticky", bus1.fault, FLT_TIMEOUT);
    chk("to_halt_pcw", bus1.pc_write, 0);
    chk("to_halt_req2", bus1.mem_req, 0);
    do_reset();
    chk("to_reset_fault", bus1.fault, 0);
    chk("to_refetch", bus1.mem_req, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
